// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared types and helpers for the external-interrupt controller.
//   irq_state_e : request/acknowledge/end-of-interrupt FSM states
//   prio_t      : result of the fixed-priority encoder (valid flag + index)
//   id_width()  : channel-ID width for a given channel count
//   prio_enc()  : lowest-set-index priority encoder over up to MAX_IRQ channels
package irq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REQ         = 3'd1,
    SERVICE     = 3'd2,
    SERVICE_REQ = 3'd3,
    NESTED      = 3'd4
  } irq_state_e;

  localparam int MAX_IRQ = 32;
  localparam int PE_W    = 5;

  typedef struct packed {
    logic            valid;
    logic [PE_W-1:0] idx;
  } prio_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scans from the top down so the lowest set index is the last one written.
  function automatic prio_t prio_enc(input logic [MAX_IRQ-1:0] vec);
    prio_t r;
    r = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = PE_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: single-line interrupt handshake between controller and core.
//   int_irq    : request, driven by the controller (master)
//   irq_id     : ID of the requested / in-service channel
//   in_service : a handler is active
//   inta_irq   : one-cycle acknowledge, driven by the core (slave)
//   eoi        : one-cycle end-of-interrupt, driven by the core
// Handshake: int_irq acts as valid and inta_irq as ready. Once int_irq is
// raised, it and irq_id stay stable until the cycle inta_irq is sampled high;
// a request is never withdrawn. eoi closes the handler that inta_irq opened.
interface irq_ctrl_if
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 8
);
  localparam int IDW = id_width(N_IRQ);

  logic           int_irq;
  logic [IDW-1:0] irq_id;
  logic           in_service;
  logic           inta_irq;
  logic           eoi;

  modport master (
    output int_irq, irq_id, in_service,
    input  inta_irq, eoi
  );

  modport slave (
    input  int_irq, irq_id, in_service,
    output inta_irq, eoi
  );
endinterface

// File: rtl/irq_sync.sv
// irq_sync: one channel's synchroniser chain plus a delayed copy for edge detect.
//   clk, rst : core clock, asynchronous active-high reset
//   d        : raw asynchronous interrupt source
//   s        : synchronised level (STAGES flops after d)
//   rise     : s high while its previous value was low
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      s_d   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      s_d   <= chain[STAGES-1];
    end
  end

  assign s    = chain[STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: N_IRQ-channel external-interrupt controller for a single-line core.
//   clk, rst  : core clock, asynchronous active-high reset
//   ex_irq    : raw interrupt sources, asynchronous to clk
//   irq_mask  : 1 = channel enabled
//   edge_sel  : 1 = rising-edge triggered, 0 = level-high triggered
//   pending   : pending latch state (status)
//   dbg_state : current FSM state
//   bus       : request/acknowledge/eoi handshake to the core (master side)
// Optional feature: define IRQ_CTRL_NEST_EN to allow one level of preemption
// by a strictly higher-priority (lower-index) channel while in SERVICE.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] ex_irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic [N_IRQ-1:0] edge_sel,
  output logic [N_IRQ-1:0] pending,
  output irq_state_e       dbg_state,
  irq_ctrl_if.master       bus
);

  localparam int IDW = id_width(N_IRQ);

  logic [N_IRQ-1:0]   s, rise, clr, pending_n;
  logic [MAX_IRQ-1:0] cand_w;
  prio_t              pe;
  logic [IDW-1:0]     win_id;
  irq_state_e         state, state_n;
  logic [IDW-1:0]     id_q, id_n;
  logic               grant;
`ifdef IRQ_CTRL_NEST_EN
  logic [IDW-1:0]     stk_q, stk_n;
`endif

  for (genvar i = 0; i < N_IRQ; i++) begin : g_ch
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (ex_irq[i]),
      .s    (s[i]),
      .rise (rise[i])
    );
  end

  assign cand_w = MAX_IRQ'(pending & irq_mask);
  assign pe     = prio_enc(cand_w);
  assign win_id = IDW'(pe.idx);

  // Only the granted channel loses its edge latch; a fresh edge in the same
  // cycle re-sets it so the event is not lost.
  assign clr = grant ? (N_IRQ'(1) << id_q) : '0;

  always_comb begin
    pending_n = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      pending_n[i] = edge_sel[i] ? (rise[i] | (pending[i] & ~clr[i])) : s[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      state   <= IDLE;
      id_q    <= '0;
`ifdef IRQ_CTRL_NEST_EN
      stk_q   <= '0;
`endif
    end else begin
      pending <= pending_n;
      state   <= state_n;
      id_q    <= id_n;
`ifdef IRQ_CTRL_NEST_EN
      stk_q   <= stk_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    id_n    = id_q;
    grant   = 1'b0;
`ifdef IRQ_CTRL_NEST_EN
    stk_n   = stk_q;
`endif
    case (state)
      IDLE: begin
        if (pe.valid) begin
          state_n = REQ;
          id_n    = win_id;
        end
      end
      REQ: begin
        if (bus.inta_irq) begin
          state_n = SERVICE;
          grant   = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          state_n = IDLE;
`ifdef IRQ_CTRL_NEST_EN
        end else if (pe.valid && (pe.idx < PE_W'(id_q))) begin
          // The interrupted handler's ID is parked until its handler resumes.
          state_n = SERVICE_REQ;
          stk_n   = id_q;
          id_n    = win_id;
`endif
        end
      end
`ifdef IRQ_CTRL_NEST_EN
      SERVICE_REQ: begin
        if (bus.inta_irq) begin
          state_n = NESTED;
          grant   = 1'b1;
        end
      end
      NESTED: begin
        if (bus.eoi) begin
          state_n = SERVICE;
          id_n    = stk_q;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign bus.int_irq    = (state == REQ) || (state == SERVICE_REQ);
  assign bus.in_service = (state == SERVICE) || (state == SERVICE_REQ) ||
                          (state == NESTED);
  assign bus.irq_id     = id_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl at default parameters.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 8;

  logic       clk;
  logic       rst;
  logic [N-1:0] ex_irq, irq_mask, edge_sel, pending;
  irq_state_e dbg_state;
  int n_chk  = 0;
  int n_fail = 0;

  irq_ctrl_if #(.N_IRQ(N)) bus ();

  irq_ctrl #(.N_IRQ(N), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_irq    (ex_irq),
    .irq_mask  (irq_mask),
    .edge_sel  (edge_sel),
    .pending   (pending),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack();
    bus.inta_irq = 1'b1;
    step();
    bus.inta_irq = 1'b0;
  endtask

  task automatic end_irq();
    bus.eoi = 1'b1;
    step();
    bus.eoi = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    ex_irq       = '0;
    irq_mask     = 8'hFF;
    edge_sel     = 8'hFD;   // ch1 level, all others edge
    bus.inta_irq = 1'b0;
    bus.eoi      = 1'b0;
    step(3);
    chk("rst_int", 32'(bus.int_irq), 32'd0);
    chk("rst_id", 32'(bus.irq_id), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_insvc", 32'(bus.in_service), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    step(2);

    // single edge on ch3, 4-cycle pulse
    ex_irq[3] = 1'b1;
    step(3);
    chk("e3_pend", 32'(pending), 32'h08);
    chk("e3_int_early", 32'(bus.int_irq), 32'd0);
    step();
    chk("e3_int", 32'(bus.int_irq), 32'd1);
    chk("e3_id", 32'(bus.irq_id), 32'd3);
    ex_irq[3] = 1'b0;
    step(2);
    chk("e3_hold", 32'(bus.int_irq), 32'd1);
    ack();
    chk("e3_ack_int", 32'(bus.int_irq), 32'd0);
    chk("e3_ack_insvc", 32'(bus.in_service), 32'd1);
    chk("e3_ack_pend", 32'(pending), 32'd0);
    step(2);
    chk("e3_svc_state", 32'(dbg_state), 32'(SERVICE));
    end_irq();
    chk("e3_eoi_state", 32'(dbg_state), 32'(IDLE));
    chk("e3_eoi_insvc", 32'(bus.in_service), 32'd0);
    step();
    chk("e3_quiet", 32'(bus.int_irq), 32'd0);

    // priority: ch5 and ch2 together
    ex_irq[5] = 1'b1;
    ex_irq[2] = 1'b1;
    step(4);
    chk("pr_int", 32'(bus.int_irq), 32'd1);
    chk("pr_id1", 32'(bus.irq_id), 32'd2);
    ex_irq[5] = 1'b0;
    ex_irq[2] = 1'b0;
    ack();
    chk("pr_pend", 32'(pending), 32'h20);
    end_irq();
    chk("pr_idle_int", 32'(bus.int_irq), 32'd0);
    step();
    chk("pr_int2", 32'(bus.int_irq), 32'd1);
    chk("pr_id2", 32'(bus.irq_id), 32'd5);
    ack();
    end_irq();
    chk("pr_done_pend", 32'(pending), 32'd0);

    // mask and level on ch1
    irq_mask  = 8'hFD;
    ex_irq[1] = 1'b1;
    step(3);
    chk("lv_pend", 32'(pending), 32'h02);
    step(2);
    chk("lv_masked", 32'(bus.int_irq), 32'd0);
    irq_mask = 8'hFF;
    step();
    chk("lv_int", 32'(bus.int_irq), 32'd1);
    chk("lv_id", 32'(bus.irq_id), 32'd1);
    ack();
    chk("lv_ack_pend", 32'(pending), 32'h02);
    end_irq();
    step();
    chk("lv_rereq", 32'(bus.int_irq), 32'd1);
    chk("lv_rereq_id", 32'(bus.irq_id), 32'd1);
    ex_irq[1] = 1'b0;
    ack();
    step(3);
    end_irq();
    step();
    chk("lv_done_int", 32'(bus.int_irq), 32'd0);
    chk("lv_done_pend", 32'(pending), 32'd0);

    // set beats clear on ch0
    ex_irq[0] = 1'b1;
    step(4);
    chk("sc_int", 32'(bus.int_irq), 32'd1);
    chk("sc_id", 32'(bus.irq_id), 32'd0);
    ex_irq[0] = 1'b0;
    step(3);
    ex_irq[0] = 1'b1;
    step(2);
    ack();
    ex_irq[0] = 1'b0;
    chk("sc_pend_kept", 32'(pending), 32'h01);
    chk("sc_insvc", 32'(bus.in_service), 32'd1);
    step(3);
    chk("sc_no_preempt", 32'(bus.int_irq), 32'd0);
    end_irq();
    step();
    chk("sc_int2", 32'(bus.int_irq), 32'd1);
    chk("sc_id2", 32'(bus.irq_id), 32'd0);
    ack();
    chk("sc_pend_clr", 32'(pending), 32'd0);
    end_irq();
    step(2);

    // reset in SERVICE with an edge source held high through reset
    ex_irq[6] = 1'b1;
    step(4);
    chk("rs_id", 32'(bus.irq_id), 32'd6);
    ack();
    chk("rs_svc", 32'(dbg_state), 32'(SERVICE));
    #2 rst = 1'b1;
    #1;
    chk("rs_int", 32'(bus.int_irq), 32'd0);
    chk("rs_insvc", 32'(bus.in_service), 32'd0);
    chk("rs_id0", 32'(bus.irq_id), 32'd0);
    chk("rs_pend", 32'(pending), 32'd0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("rs_pend_after", 32'(pending), 32'h40);
    step();
    chk("rs_int_after", 32'(bus.int_irq), 32'd1);
    chk("rs_id_after", 32'(bus.irq_id), 32'd6);
    ex_irq[6] = 1'b0;
    ack();
    end_irq();
    step(3);
    chk("rs_single", 32'(bus.int_irq), 32'd0);

    // ch4 in service, higher-priority ch1 edge arrives
    edge_sel  = 8'hFF;
    ex_irq[4] = 1'b1;
    step(4);
    chk("ns_id4", 32'(bus.irq_id), 32'd4);
    ex_irq[4] = 1'b0;
    ack();
    ex_irq[1] = 1'b1;
    step(3);
    chk("ns_pend1", 32'(pending), 32'h02);
    step();
    ex_irq[1] = 1'b0;
`ifdef IRQ_CTRL_NEST_EN
    chk("ns_int", 32'(bus.int_irq), 32'd1);
    chk("ns_id1", 32'(bus.irq_id), 32'd1);
    chk("ns_sreq", 32'(dbg_state), 32'(SERVICE_REQ));
    ack();
    chk("ns_nested", 32'(dbg_state), 32'(NESTED));
    chk("ns_nested_int", 32'(bus.int_irq), 32'd0);
    end_irq();
    chk("ns_restore_id", 32'(bus.irq_id), 32'd4);
    chk("ns_restore_insvc", 32'(bus.in_service), 32'd1);
    chk("ns_restore_state", 32'(dbg_state), 32'(SERVICE));
    end_irq();
    chk("ns_idle", 32'(dbg_state), 32'(IDLE));
    step();
    chk("ns_quiet", 32'(bus.int_irq), 32'd0);
`else
    chk("np_int", 32'(bus.int_irq), 32'd0);
    chk("np_id", 32'(bus.irq_id), 32'd4);
    end_irq();
    step();
    chk("np_int_after", 32'(bus.int_irq), 32'd1);
    chk("np_id_after", 32'(bus.irq_id), 32'd1);
    ack();
    end_irq();
    step();
    chk("np_quiet", 32'(bus.int_irq), 32'd0);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
